// File: rtl/uart_pkg.sv
// Shared UART definitions: auto-baud FSM state encoding and the widths used
// between the auto-baud controller and the 16x baud clock generator.
package uart_pkg;

    localparam int BAUD_VAL_W      = 13;  // generator integer divisor width
    localparam int FRAC_W          = 3;   // generator eighth-fraction width
    localparam int OVERSAMPLE_LOG2 = 4;   // 16x oversampling
    localparam int SYNC_EDGES      = 5;   // falling edges in a 0x55 frame

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        WAIT_START,
        MEASURE,
        CALC,
        LOCKED,
        ERROR
    } state_t;

endpackage

// File: rtl/autobaud_ctrl_if.sv
// Control/status bundle between the APB register block (master) and the
// auto-baud controller (slave), including the divisor handed to the clock
// generator.
//   autobaud_start/autobaud_en     : measurement control
//   cfg_baud_val/cfg_fraction      : software divisor used when not locked
//   baud_val/baud_val_fraction     : divisor presented to the generator
//   baud_load/locked/busy/err      : status
interface autobaud_ctrl_if;
    import uart_pkg::*;

    logic                  autobaud_start;
    logic                  autobaud_en;
    logic [BAUD_VAL_W-1:0] cfg_baud_val;
    logic [FRAC_W-1:0]     cfg_fraction;
    logic [BAUD_VAL_W-1:0] baud_val;
    logic [FRAC_W-1:0]     baud_val_fraction;
    logic                  baud_load;
    logic                  locked;
    logic                  busy;
    logic                  err;

    modport master (
        output autobaud_start, autobaud_en, cfg_baud_val, cfg_fraction,
        input  baud_val, baud_val_fraction, baud_load, locked, busy, err
    );

    modport slave (
        input  autobaud_start, autobaud_en, cfg_baud_val, cfg_fraction,
        output baud_val, baud_val_fraction, baud_load, locked, busy, err
    );

endinterface

// File: rtl/rx_edge_sync.sv
// RX pin conditioning: 2-flop synchroniser followed by an edge register.
//   clk, reset_n : clock and active-low reset (async unless SYNC_RESET=1)
//   rx           : raw asynchronous serial input
//   rx_sync      : synchronised RX level
//   fe           : falling edge of rx_sync (one clock wide)
module rx_edge_sync #(
    parameter int SYNC_RESET = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rx,
    output logic rx_sync,
    output logic fe
);

    logic aresetn;
    logic sresetn;
    logic sync1;
    logic sync2;
    logic sync2_d;

    assign aresetn = (SYNC_RESET == 1) ? 1'b1 : reset_n;
    assign sresetn = (SYNC_RESET == 1) ? reset_n : 1'b1;

    // Reset to the idle (high) line level so no edge is seen out of reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn || !sresetn) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            sync2_d <= 1'b1;
        end else begin
            sync1   <= rx;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign rx_sync = sync2;
    assign fe      = sync2_d & ~sync2;

endmodule

// File: rtl/autobaud_ctrl.sv
// Auto-baud controller for the UART 16x baud clock generator.
// Measures the span of 8 bit times in a received 0x55 sync character and
// derives baud_val = N/128 - 1 and baud_val_fraction = N[6:4]; falls back to
// the software values whenever no lock is held.
//   clk, reset_n : clock and active-low reset (async unless SYNC_RESET=1)
//   rx           : raw serial input
//   bus          : autobaud_ctrl_if slave (control, cfg values, divisor, status)
// Optional: define AUTOBAUD_EDGE_CHECK_EN to require edge intervals 2..4 to be
// within +/-1/8 of the first interval.
module autobaud_ctrl
    import uart_pkg::*;
#(
    parameter int CNT_W      = 20,
    parameter int IDLE_CYC   = 16,
    parameter int SYNC_RESET = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    autobaud_ctrl_if.slave  bus
);

    localparam int IDLE_W = $clog2(IDLE_CYC + 1);
    localparam int SHIFT  = OVERSAMPLE_LOG2 + 3;  // 16x oversample * 8 bits

    logic aresetn;
    logic sresetn;
    assign aresetn = (SYNC_RESET == 1) ? 1'b1 : reset_n;
    assign sresetn = (SYNC_RESET == 1) ? reset_n : 1'b1;

    logic rx_sync;
    logic fe;

    rx_edge_sync #(.SYNC_RESET(SYNC_RESET)) u_rx_edge_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .rx_sync (rx_sync),
        .fe      (fe)
    );

    state_t                state, next_state;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [CNT_W-1:0]      n_reg, n_nxt;
    logic [2:0]            edge_cnt, edge_nxt;
    logic [IDLE_W-1:0]     idle_cnt, idle_nxt;
    logic [BAUD_VAL_W-1:0] meas_val, meas_val_nxt;
    logic [FRAC_W-1:0]     meas_frac, meas_frac_nxt;
    logic                  err_r, err_nxt;
    logic                  load_r;
    logic [31:0]           n_hi;
    logic                  edge_bad;

`ifdef AUTOBAUD_EDGE_CHECK_EN
    logic [CNT_W-1:0] i1, i1_nxt;
    logic [CNT_W-1:0] last_edge, last_edge_nxt;
    logic [CNT_W-1:0] interval, tol, lo_lim;
    logic [CNT_W:0]   hi_lim;
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn || !sresetn) begin
            state     <= IDLE;
            cnt       <= '0;
            n_reg     <= '0;
            edge_cnt  <= '0;
            idle_cnt  <= '0;
            meas_val  <= '0;
            meas_frac <= '0;
            err_r     <= 1'b0;
            load_r    <= 1'b0;
`ifdef AUTOBAUD_EDGE_CHECK_EN
            i1        <= '0;
            last_edge <= '0;
`endif
        end else begin
            state     <= next_state;
            cnt       <= cnt_nxt;
            n_reg     <= n_nxt;
            edge_cnt  <= edge_nxt;
            idle_cnt  <= idle_nxt;
            meas_val  <= meas_val_nxt;
            meas_frac <= meas_frac_nxt;
            err_r     <= err_nxt;
            load_r    <= (state == CALC) && (next_state == LOCKED);
`ifdef AUTOBAUD_EDGE_CHECK_EN
            i1        <= i1_nxt;
            last_edge <= last_edge_nxt;
`endif
        end
    end

    always_comb begin
        next_state    = state;
        cnt_nxt       = cnt;
        n_nxt         = n_reg;
        edge_nxt      = edge_cnt;
        idle_nxt      = idle_cnt;
        meas_val_nxt  = meas_val;
        meas_frac_nxt = meas_frac;
        err_nxt       = err_r;
        edge_bad      = 1'b0;
        n_hi          = 32'(n_reg >> SHIFT);
`ifdef AUTOBAUD_EDGE_CHECK_EN
        i1_nxt        = i1;
        last_edge_nxt = last_edge;
        interval      = cnt - last_edge;
        tol           = i1 >> 3;
        lo_lim        = i1 - tol;
        hi_lim        = {1'b0, i1} + {1'b0, tol};
`endif

        // Disable outranks start; start in any busy/locked state restarts.
        if (!bus.autobaud_en) begin
            next_state = IDLE;
            cnt_nxt    = '0;
            edge_nxt   = '0;
            idle_nxt   = '0;
        end else if (bus.autobaud_start) begin
            next_state = WAIT_IDLE;
            cnt_nxt    = '0;
            edge_nxt   = '0;
            idle_nxt   = '0;
            err_nxt    = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                WAIT_IDLE: begin
                    if (rx_sync) begin
                        if (idle_cnt == IDLE_W'(IDLE_CYC - 1))
                            next_state = WAIT_START;
                        else
                            idle_nxt = idle_cnt + 1'b1;
                    end else begin
                        idle_nxt = '0;
                    end
                end
                WAIT_START: begin
                    if (fe) begin
                        cnt_nxt    = CNT_W'(1);
                        edge_nxt   = 3'd1;
                        next_state = MEASURE;
`ifdef AUTOBAUD_EDGE_CHECK_EN
                        last_edge_nxt = '0;
`endif
                    end
                end
                MEASURE: begin
                    cnt_nxt = cnt + 1'b1;
                    if (fe) begin
                        edge_nxt = edge_cnt + 3'd1;
`ifdef AUTOBAUD_EDGE_CHECK_EN
                        last_edge_nxt = cnt;
                        if (edge_cnt == 3'd1)
                            i1_nxt = interval;
                        else
                            edge_bad = (interval < lo_lim) ||
                                       ({1'b0, interval} > hi_lim);
`endif
                        if (edge_bad) begin
                            next_state = ERROR;
                        end else if (edge_cnt == 3'(SYNC_EDGES - 1)) begin
                            n_nxt      = cnt;
                            next_state = CALC;
                        end else if (cnt == '1) begin
                            next_state = ERROR;
                        end
                    end else if (cnt == '1) begin
                        next_state = ERROR;
                    end
                end
                CALC: begin
                    if (n_hi == 32'd0) begin
                        next_state = ERROR;
                    end else begin
                        meas_val_nxt  = BAUD_VAL_W'(n_hi - 32'd1);
                        meas_frac_nxt = n_reg[SHIFT-1:OVERSAMPLE_LOG2];
                        next_state    = (n_hi > 32'd8192) ? ERROR : LOCKED;
                    end
                end
                LOCKED: ;
                ERROR:  next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end

        if (next_state == ERROR)
            err_nxt = 1'b1;
    end

    assign bus.locked            = (state == LOCKED);
    assign bus.busy              = state inside {WAIT_IDLE, WAIT_START, MEASURE, CALC};
    assign bus.err               = err_r;
    assign bus.baud_load         = load_r;
    assign bus.baud_val          = bus.locked ? meas_val  : bus.cfg_baud_val;
    assign bus.baud_val_fraction = bus.locked ? meas_frac : bus.cfg_fraction;

endmodule
